// File: rtl/multiplyadd_seq_pkg.sv
// Shared constants, state encoding and helpers for the MAC sequencer.
package multiplyadd_pkg;

    localparam int OP_W       = 8;
    localparam int RES_W      = 17;
    localparam int LEN_W      = 8;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        DRAIN1 = 3'd3,
        DRAIN2 = 3'd4,
        DONE   = 3'd5
    } state_e;

    // Accumulator wrapped since the last sample: every single add is below
    // 2^16, so a decrease of the running sum means exactly one wrap.
    function automatic logic acc_wrapped(input logic [RES_W-1:0] cur,
                                         input logic [RES_W-1:0] prev);
        return (cur < prev);
    endfunction

endpackage

// File: rtl/multiplyadd_seq_if.sv
// Operand input stream and result output stream of the MAC sequencer.
interface multiplyadd_seq_if #(
    parameter int OP_W  = 8,
    parameter int RES_W = 17
) ();
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_a;
    logic [OP_W-1:0]  in_b;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_result;
    logic             out_ovf;

    // Sequencer side
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_ovf
    );

    // Producer / consumer side
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_ovf
    );
endinterface

// File: rtl/multiplyadd_seq_fifo.sv
// Small synchronous FIFO holding {a,b} operand pairs; occupancy counter
// drives full/empty so no pointer-wrap bit is needed.
module mac_operand_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == {CNT_W{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rdata     = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset empties the queue and clears storage
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/multiplyadd_seq.sv
// Control stage in front of an 8x8 multiply-accumulate unit: buffers
// operand pairs, clears the accumulator per vector, streams one pair per
// cycle (zeros when starved) and captures the final sum with a wrap flag.
module multiplyadd_seq
    import multiplyadd_pkg::*;
#(
    parameter int OP_W       = multiplyadd_pkg::OP_W,
    parameter int RES_W      = multiplyadd_pkg::RES_W,
    parameter int LEN_W      = multiplyadd_pkg::LEN_W,
    parameter int FIFO_DEPTH = multiplyadd_pkg::FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     vec_len,
    output logic                 busy,
    output logic [OP_W-1:0]      mac_a,
    output logic [OP_W-1:0]      mac_b,
    output logic                 mac_clr,
    input  logic [RES_W-1:0]     mac_result,
    multiplyadd_seq_if.slave     bus
);
    state_e              state_q, state_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [OP_W-1:0]     mac_a_q, mac_a_d;
    logic [OP_W-1:0]     mac_b_q, mac_b_d;
    logic                mac_clr_q, mac_clr_d;
    logic [RES_W-1:0]    prev_res_q, prev_res_d;
    logic                out_valid_q, out_valid_d;
    logic [RES_W-1:0]    out_result_q, out_result_d;
    logic                out_ovf_q, out_ovf_d;
    logic                busy_q, busy_d;

    logic                fifo_push_s;
    logic                fifo_pop_s;
    logic [2*OP_W-1:0]   fifo_rdata_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;

    // Accept an operand pair whenever there is room, regardless of state
    assign fifo_push_s = bus.in_valid && !fifo_full_s;
    assign bus.in_ready = !fifo_full_s;

    mac_operand_fifo #(
        .W     (2 * OP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push_s),
        .wdata ({bus.in_a, bus.in_b}),
        .pop   (fifo_pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Sequencer next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        mac_a_d      = {OP_W{1'b0}};
        mac_b_d      = {OP_W{1'b0}};
        mac_clr_d    = 1'b0;
        prev_res_d   = prev_res_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_ovf_d    = out_ovf_q;
        fifo_pop_s   = 1'b0;

        // Wrap tracking runs in every state where the accumulator moves
        if ((state_q == RUN) || (state_q == DRAIN1) || (state_q == DRAIN2)) begin
            if (acc_wrapped(mac_result, prev_res_q)) begin
                out_ovf_d = 1'b1;
            end else begin
                out_ovf_d = out_ovf_q;
            end
            prev_res_d = mac_result;
        end else begin
            prev_res_d = prev_res_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = vec_len;
                    mac_clr_d   = 1'b1;
                    state_d     = CLEAR;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                prev_res_d = {RES_W{1'b0}};
                out_ovf_d  = 1'b0;
                if (remaining_q != {LEN_W{1'b0}}) begin
                    state_d = RUN;
                end else begin
                    state_d = DRAIN1;
                end
            end
            RUN: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s  = 1'b1;
                    mac_a_d     = fifo_rdata_s[2*OP_W-1:OP_W];
                    mac_b_d     = fifo_rdata_s[OP_W-1:0];
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = DRAIN1;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    // Starved: zero operands leave the accumulator unchanged
                    state_d = RUN;
                end
            end
            DRAIN1: begin
                state_d = DRAIN2;
            end
            DRAIN2: begin
                out_result_d = mac_result;
                out_valid_d  = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Sequencer state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            remaining_q  <= {LEN_W{1'b0}};
            mac_a_q      <= {OP_W{1'b0}};
            mac_b_q      <= {OP_W{1'b0}};
            mac_clr_q    <= 1'b0;
            prev_res_q   <= {RES_W{1'b0}};
            out_valid_q  <= 1'b0;
            out_result_q <= {RES_W{1'b0}};
            out_ovf_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            mac_a_q      <= mac_a_d;
            mac_b_q      <= mac_b_d;
            mac_clr_q    <= mac_clr_d;
            prev_res_q   <= prev_res_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_ovf_q    <= out_ovf_d;
            busy_q       <= busy_d;
        end
    end

    assign mac_a          = mac_a_q;
    assign mac_b          = mac_b_q;
    assign mac_clr        = mac_clr_q;
    assign busy           = busy_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_multiplyadd_seq.sv
// Self-checking bench for multiplyadd_seq with a simple MAC attached.
module tb_multiplyadd_seq;
    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  vec_len;
    logic        busy;
    logic [7:0]  mac_a, mac_b;
    logic        mac_clr;
    logic [16:0] mac_acc;
    logic [15:0] prod;

    int tests = 0;
    int fails = 0;
    int clr_pulses = 0;
    logic [15:0] model_q[$];   // {a,b} pairs expected to sit in the FIFO

    multiplyadd_seq_if bus ();

    multiplyadd_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .vec_len    (vec_len),
        .busy       (busy),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_clr    (mac_clr),
        .mac_result (mac_acc),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External MAC: register reset tied to reset | mac_clr, adds a*b every clock
    assign prod = 16'(mac_a) * 16'(mac_b);
    always_ff @(posedge clk) begin
        if (reset || mac_clr) mac_acc <= 17'd0;
        else                  mac_acc <= mac_acc + 17'(prod);
    end

    always_ff @(posedge clk) begin
        if (mac_clr) clr_pulses <= clr_pulses + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair; the model decides acceptance from its own occupancy
    task automatic push_pair(input logic [7:0] a, input logic [7:0] b, input string name);
        logic exp_rdy;
        exp_rdy = (model_q.size() < 4);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        tests++;
        if (bus.in_ready !== exp_rdy) begin
            fails++;
            $display("FAIL %s in_ready got %0b expected %0b", name, bus.in_ready, exp_rdy);
        end
        step();
        bus.in_valid = 1'b0;
        if (exp_rdy) model_q.push_back({a, b});
    endtask

    // Wait for the result, then compare against the arithmetic of the next len pairs
    task automatic wait_result(input int len, input int edges_in, input int exp_edges,
                               input bit accept, input string name);
        int edges;
        int sum;
        logic [15:0] pr;
        logic [16:0] exp_res;
        logic exp_ovf;
        edges = edges_in;
        sum = 0;
        while (!bus.out_valid && edges < 300) begin
            step();
            edges++;
        end
        tests++;
        if (!bus.out_valid) begin
            fails++;
            $display("FAIL %s timeout waiting for out_valid after %0d edges", name, edges);
        end
        for (int i = 0; i < len; i++) begin
            if (model_q.size() > 0) begin
                pr = model_q.pop_front();
                sum += int'(pr[15:8]) * int'(pr[7:0]);
            end
        end
        exp_res = 17'(sum % 131072);
        exp_ovf = (sum >= 131072);
        tests++;
        if (bus.out_result !== exp_res) begin
            fails++;
            $display("FAIL %s out_result got %0d expected %0d", name, bus.out_result, exp_res);
        end
        tests++;
        if (bus.out_ovf !== exp_ovf) begin
            fails++;
            $display("FAIL %s out_ovf got %0b expected %0b", name, bus.out_ovf, exp_ovf);
        end
        tests++;
        if (edges != exp_edges) begin
            fails++;
            $display("FAIL %s latency got %0d edges expected %0d", name, edges, exp_edges);
        end
        if (accept) begin
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            tests++;
            if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL %s after accept out_valid=%0b busy=%0b expected 0 0", name, bus.out_valid, busy);
            end
        end
    endtask

    // Start a vector from a preloaded FIFO; latency counts the start edge as edge 1
    task automatic run_vec(input int len, input string name);
        int c0;
        c0 = clr_pulses;
        start = 1'b1; vec_len = 8'(len);
        step();
        start = 1'b0; vec_len = 8'd0;
        wait_result(len, 1, len + 4, 1'b1, name);
        tests++;
        if (clr_pulses - c0 != 1) begin
            fails++;
            $display("FAIL %s mac_clr pulses got %0d expected 1", name, clr_pulses - c0);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        tests++;
        if (mac_a !== 8'd0 || mac_b !== 8'd0 || mac_clr !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.out_result !== 17'd0 || bus.out_ovf !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s outputs a=%0d b=%0d clr=%0b ov=%0b res=%0d ovf=%0b busy=%0b expected all 0",
                     name, mac_a, mac_b, mac_clr, bus.out_valid, bus.out_result, bus.out_ovf, busy);
        end
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s in_ready got %0b expected 1", name, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        check_idle_outputs("reset_held");
        reset = 1'b0;
        step();
        check_idle_outputs("reset_released");
    endtask

    task automatic test_basic();
        push_pair(8'd2, 8'd3, "basic_push");
        push_pair(8'd4, 8'd5, "basic_push");
        push_pair(8'd10, 8'd10, "basic_push");
        run_vec(3, "basic_126");
    endtask

    task automatic test_gap();
        push_pair(8'd7, 8'd9, "gap_push1");
        start = 1'b1; vec_len = 8'd2;
        step();                         // edge 1: start sampled
        start = 1'b0; vec_len = 8'd0;
        step(); step(); step();         // edges 2..4: clear, first pop, first bubble
        tests++;
        if (mac_a !== 8'd0 || mac_b !== 8'd0) begin
            fails++;
            $display("FAIL gap_bubble1 mac_a=%0d mac_b=%0d expected 0 0", mac_a, mac_b);
        end
        step();                         // edge 5
        tests++;
        if (mac_a !== 8'd0 || mac_b !== 8'd0) begin
            fails++;
            $display("FAIL gap_bubble2 mac_a=%0d mac_b=%0d expected 0 0", mac_a, mac_b);
        end
        push_pair(8'd1, 8'd1, "gap_push2");   // edge 6
        wait_result(2, 6, 2 + 4 + 3, 1'b1, "gap_64");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) push_pair(8'd255, 8'd255, "ovf_push");
        run_vec(3, "ovf_64003");
        push_pair(8'd1, 8'd1, "ovf_follow_push");
        run_vec(1, "ovf_follow_1");
    endtask

    task automatic test_zero_len();
        push_pair(8'd5, 8'd6, "zero_push");
        run_vec(0, "zero_len");
        run_vec(1, "zero_fifo_kept_30");
    endtask

    task automatic test_hold();
        push_pair(8'd2, 8'd2, "hold_push");
        start = 1'b1; vec_len = 8'd1;
        step();
        start = 1'b0; vec_len = 8'd0;
        wait_result(1, 1, 5, 1'b0, "hold_result");
        bus.out_ready = 1'b0;
        start = 1'b1; vec_len = 8'd3;
        step();
        start = 1'b0; vec_len = 8'd0;
        tests++;
        if (busy !== 1'b1 || mac_clr !== 1'b0 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL hold_start_ignored busy=%0b clr=%0b ov=%0b expected 1 0 1", busy, mac_clr, bus.out_valid);
        end
        push_pair(8'd11, 8'd12, "hold_fill");
        push_pair(8'd13, 8'd14, "hold_fill");
        push_pair(8'd15, 8'd16, "hold_fill");
        push_pair(8'd17, 8'd18, "hold_fill");
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold_full in_ready got %0b expected 0", bus.in_ready);
        end
        push_pair(8'd99, 8'd99, "hold_fifth");   // model expects refusal
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 17'd4 || bus.out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL hold_held ov=%0b res=%0d ovf=%0b expected 1 4 0", bus.out_valid, bus.out_result, bus.out_ovf);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL hold_release ov=%0b busy=%0b expected 0 0", bus.out_valid, busy);
        end
        run_vec(4, "hold_drain4");
        push_pair(8'd9, 8'd9, "hold_marker_push");
        run_vec(1, "hold_marker_81");
    endtask

    task automatic test_reset_mid();
        push_pair(8'd20, 8'd21, "rst_push");
        push_pair(8'd22, 8'd23, "rst_push");
        push_pair(8'd24, 8'd25, "rst_push");
        start = 1'b1; vec_len = 8'd3;
        step();
        start = 1'b0; vec_len = 8'd0;
        step(); step();                 // first pair popped, two remaining
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_q.delete();
        check_idle_outputs("reset_mid");
        push_pair(8'd3, 8'd3, "rst_new_push");
        run_vec(1, "reset_then_9");
    endtask

    task automatic test_random();
        int len;
        for (int it = 0; it < 8; it++) begin
            len = int'($urandom_range(1, 4));
            for (int k = 0; k < len; k++) begin
                push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rand_push");
            end
            run_vec(len, "rand_vec");
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; vec_len = 8'd0;
        bus.in_valid = 1'b0; bus.in_a = 8'd0; bus.in_b = 8'd0; bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_gap();
        test_overflow();
        test_zero_len();
        test_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
